// File: rtl/lib_arbiter_pkg.sv
// lib_arbiter_pkg: shared widths, extended-timestamp type and unwrapper state encoding
package lib_arbiter_pkg;

    localparam int SIZE            = 8;
    localparam int EPOCH_W_DEFAULT = 8;

    typedef logic [SIZE+EPOCH_W_DEFAULT-1:0] ext_ts_t;

    typedef enum logic {NO_REF, RUN} unwrap_state_e;

endpackage

// File: rtl/ts_skid_buffer.sv
// ts_skid_buffer: 2-entry valid/ready buffer with a registered input ready
//   clk_i, reset_i           clock, asynchronous active-high reset
//   in_data_i/in_valid_i     upstream payload and valid
//   in_ready_o               registered ready, low while the skid entry is occupied
//   out_data_o/out_valid_o   output register payload and valid
//   out_ready_i              downstream accept
//   fresh_o                  high the first cycle a new entry sits in the output register
module ts_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         fresh_o
);

    logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic         ready_q, fresh_q, fresh_d, push, load;

    // load: the output register is empty or is being emptied this cycle
    always_comb begin
        push         = in_valid_i && ready_q;
        load         = !out_valid_q || out_ready_i;
        out_valid_d  = load ? (skid_valid_q || push) : out_valid_q;
        out_data_d   = !load ? out_data_q : skid_valid_q ? skid_data_q : push ? in_data_i : out_data_q;
        skid_valid_d = skid_valid_q ? !load : (push && !load);
        skid_data_d  = (push && !load) ? in_data_i : skid_data_q;
        fresh_d      = load && (skid_valid_q || push);
    end

    // ready resets low and rises on the first clock after reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            fresh_q      <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
            fresh_q      <= fresh_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign fresh_o     = fresh_q;

endmodule

// File: rtl/event_ts_unwrapper.sv
// event_ts_unwrapper: extends wrapped SIZE-bit event timestamps with an epoch counter
//   clk_i, reset_i           clock, asynchronous active-high reset
//   ts_i/ts_valid_i          wrapped timestamp in, valid
//   ts_ready_o               registered ready
//   ext_ts_o/ext_valid_o     {epoch, ts} out, valid
//   ext_ready_i              downstream accept
//   wrap_o                   pulse when an entry that advanced the epoch reaches the output
//   order_err_o/epoch_ovf_o  sticky out-of-order and epoch-overflow flags
//   clr_err_i                synchronous clear of both sticky flags (a same-cycle set wins)
module event_ts_unwrapper
    import lib_arbiter_pkg::*;
#(
    parameter int EPOCH_W = EPOCH_W_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [SIZE-1:0]         ts_i,
    input  logic                    ts_valid_i,
    output logic                    ts_ready_o,
    output logic [SIZE+EPOCH_W-1:0] ext_ts_o,
    output logic                    ext_valid_o,
    input  logic                    ext_ready_i,
    output logic                    wrap_o,
    output logic                    order_err_o,
    output logic                    epoch_ovf_o,
    input  logic                    clr_err_i
);

    localparam int EW = SIZE + EPOCH_W;

    unwrap_state_e      state_q, state_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d, epoch_inc;
    logic [SIZE-1:0]    last_ts_q, last_ts_d, diff;
    logic               order_err_q, order_err_d, epoch_ovf_q, epoch_ovf_d;
    logic               push, behind, is_wrap, is_ooo, fresh;
    logic [EW:0]        in_data, out_data;

    // A step backwards of at least half the range is a wrap; a shorter one is a late event
    always_comb begin
        push        = ts_valid_i && ts_ready_o;
        diff        = last_ts_q - ts_i;
        behind      = (state_q == RUN) && (ts_i < last_ts_q);
        is_wrap     = behind && diff[SIZE-1];
        is_ooo      = behind && !diff[SIZE-1];
        epoch_inc   = epoch_q + EPOCH_W'(1);
        state_d     = push ? RUN : state_q;
        epoch_d     = (push && is_wrap) ? epoch_inc : epoch_q;
        last_ts_d   = (push && !is_ooo) ? ts_i : last_ts_q;
        order_err_d = (push && is_ooo) || (order_err_q && !clr_err_i);
        epoch_ovf_d = (push && is_wrap && (&epoch_q)) || (epoch_ovf_q && !clr_err_i);
        in_data     = {(is_wrap ? epoch_inc : epoch_q), ts_i, is_wrap};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= NO_REF;
            epoch_q     <= '0;
            last_ts_q   <= '0;
            order_err_q <= 1'b0;
            epoch_ovf_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            epoch_q     <= epoch_d;
            last_ts_q   <= last_ts_d;
            order_err_q <= order_err_d;
            epoch_ovf_q <= epoch_ovf_d;
        end
    end

    ts_skid_buffer #(.W(EW + 1)) u_buf (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .in_data_i  (in_data),
        .in_valid_i (ts_valid_i),
        .in_ready_o (ts_ready_o),
        .out_data_o (out_data),
        .out_valid_o(ext_valid_o),
        .out_ready_i(ext_ready_i),
        .fresh_o    (fresh)
    );

    assign ext_ts_o    = out_data[EW:1];
    assign wrap_o      = fresh && out_data[0];
    assign order_err_o = order_err_q;
    assign epoch_ovf_o = epoch_ovf_q;

endmodule

// File: doc/event_ts_unwrapper.md
# event_ts_unwrapper

Consumer-side counterpart of the pixel-hierarchy wall clock. It accepts the stream of wrapped SIZE-bit event timestamps emitted by the arbiter tree and reconstructs a monotonic extended timestamp of width SIZE+EPOCH_W by tracking counter wrap-arounds. It sits between the top-level arbiter output and the event packetizer, with a valid/ready interface and a registered ready on both sides.

## Interface
- SIZE, from lib_arbiter_pkg: width of the wrapped timestamp, identical to the wall clock width.
- EPOCH_W, 8: width of the epoch (wrap) counter.
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- ts_i  in  SIZE  wrapped timestamp of the incoming event.
- ts_valid_i  in  1  ts_i valid.
- ts_ready_o  out  1  unwrapper can accept; registered.
- ext_ts_o  out  SIZE+EPOCH_W  extended timestamp, {epoch, ts}.
- ext_valid_o  out  1  ext_ts_o valid.
- ext_ready_i  in  1  downstream accepts.
- wrap_o  out  1  one-cycle pulse when an accepted event advanced the epoch.
- order_err_o  out  1  sticky: an out-of-order timestamp was seen.
- epoch_ovf_o  out  1  sticky: the epoch counter wrapped from all-ones to 0.
- clr_err_i  in  1  synchronous clear of both sticky flags.

## Operation
- Input transfer happens when ts_valid_i && ts_ready_o. Output transfer happens when ext_valid_o && ext_ready_i.
- State machine:
  - NO_REF (after reset): the first accepted event outputs {0, ts_i}, loads last_ts, and moves to RUN.
  - RUN: each accepted event is classified against last_ts using d = (last_ts - ts_i) mod 2^SIZE.
  - ts_i >= last_ts: same epoch, in order.
  - ts_i < last_ts and d >= 2^(SIZE-1): wrap. Epoch increments, wrap_o pulses, and the output is {epoch+1, ts_i}.
  - ts_i < last_ts and d < 2^(SIZE-1): out of order. The event is still forwarded with {epoch, ts_i}. order_err_o is set. last_ts is not updated.
- In-order and wrap events update last_ts to ts_i.
- Epoch arithmetic is modulo 2^EPOCH_W. An increment from all-ones sets epoch_ovf_o.
- Flag priority: a set event and clr_err_i in the same cycle leaves the flag set (set wins).
- There is no drop path. Every accepted event produces exactly one output in arrival order.

## Timing
- Reset values: ts_ready_o=0 during reset and 1 on the first cycle after reset. ext_valid_o=0, ext_ts_o=0, wrap_o=0, order_err_o=0, epoch_ovf_o=0, epoch=0, last_ts=0, state NO_REF.
- Latency is 1 cycle from input transfer to ext_valid_o, with an empty buffer.
- wrap_o is aligned to the input-transfer cycle +1, i.e. the same cycle the corresponding entry first enters the output register.
- Output buffering uses a 2-entry skid buffer, so ts_ready_o is a register, not a combinational path from ext_ready_i.
- Throughput is 1 event/cycle while ext_ready_i=1.
- ts_ready_o falls 1 cycle after the buffer holds 2 entries.
- ext_ts_o and ext_valid_o are held stable while ext_valid_o && !ext_ready_i.
- Equal consecutive timestamps (ts_i == last_ts) count as in order, with no wrap.
- Reset mid-operation clears the buffered events, the epoch and the state. Behaviour restarts in NO_REF.

## Structure
- lib_arbiter_pkg: SIZE (existing); add EPOCH_W default, a typedef for the extended timestamp, and the state enum {NO_REF, RUN}.
- Sub-module ts_skid_buffer: a 2-entry valid/ready buffer, parameterized on data width. It carries {ext_ts, wrap flag}. The unwrap datapath and FSM live in event_ts_unwrapper.

## Test plan
SIZE=8 and EPOCH_W=4 for all directed tests.
- Reset then ts 10,20,30 with ext_ready_i=1 → ext_ts 0x00A, 0x014, 0x01E, each 1 cycle after acceptance; wrap_o never pulses.
- Ts 250 then 5 → outputs 0x0FA, 0x105; wrap_o pulses once with the second output.
- Ts 100 then 90 → outputs 0x064, 0x05A; order_err_o sets and stays; the next ts 95 is classified against 100 (out of order again). clr_err_i then clears the flag.
- 16 consecutive wraps (ts 200,10,200,10,...) → epoch returns to 0 and epoch_ovf_o sets on the 16th wrap.
- ext_ready_i=0 for 5 cycles during a back-to-back stream → ts_ready_o drops after 2 buffered events. There is no loss, no duplication, and order is preserved on release; the output is stable while stalled.
- reset_i asserted for 1 cycle while 2 entries are buffered → ext_valid_o=0 immediately. The next ts 7 outputs 0x007 (NO_REF path).
